// File: rtl/regfile_decoder_pipe.sv
// Pipelined N-to-2^N split-predecode decoder for register-file select. Latency is 2 cycles. Valid/ready on both
// sides; up to 2 requests are held under back-pressure. Defining DEC_ONEHOT_CHECK_EN adds a sticky err output.
module regfile_decoder_pipe #(
  parameter int N         = 5,
  parameter int HI_BITS   = 3,
  parameter int MASK_ZERO = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_en,
  input  logic [N-1:0]      in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      out_sel
`ifdef DEC_ONEHOT_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int LO_BITS = N - HI_BITS;
  localparam int HW      = 1 << HI_BITS;
  localparam int LW      = 1 << LO_BITS;
  localparam int OW      = 1 << N;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("regfile_decoder_pipe: N must be in 2..8");
  end
  if (HI_BITS < 1 || HI_BITS > N - 1) begin : g_bad_hi
    $error("regfile_decoder_pipe: HI_BITS must be in 1..N-1");
  end
  if (MASK_ZERO != 0 && MASK_ZERO != 1) begin : g_bad_mz
    $error("regfile_decoder_pipe: MASK_ZERO must be 0 or 1");
  end

  logic          s1_valid_q, s1_valid_d;
  logic [HW-1:0] s1_hi_q, s1_hi_d;
  logic [LW-1:0] s1_lo_q, s1_lo_d;
  logic [N-1:0]  s1_sel_q, s1_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_q, out_d;
  logic [N-1:0]  out_sel_q, out_sel_d;

  logic [HW-1:0] hi_dec;
  logic [LW-1:0] lo_dec;
  logic [OW-1:0] comb_out;
  logic          in_xfer;
  logic          s2_adv;

  for (genvar k = 0; k < HW; k++) begin : g_hi
    assign hi_dec[k] = in_en & (in_sel[N-1:LO_BITS] == HI_BITS'(k));
  end
  for (genvar j = 0; j < LW; j++) begin : g_lo
    assign lo_dec[j] = in_en & (in_sel[LO_BITS-1:0] == LO_BITS'(j));
  end
  // Entry 0 is the hardwired zero register when MASK_ZERO is set.
  for (genvar i = 0; i < OW; i++) begin : g_and
    if (MASK_ZERO != 0 && i == 0) begin : g_mask
      assign comb_out[i] = 1'b0;
    end else begin : g_pass
      assign comb_out[i] = s1_hi_q[i / LW] & s1_lo_q[i % LW];
    end
  end

  assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ctrl_reset_n & (~s1_valid_q | s2_adv);
  assign in_xfer  = in_valid & in_ready;

`ifdef DEC_ONEHOT_CHECK_EN
  logic s1_en_q, s1_en_d;
  logic out_en_q, out_en_d;
  logic err_q, err_d;
  logic multi_hot;

  assign multi_hot = |(out_q & (out_q - OW'(1)));

  always_comb begin
    s1_en_d  = s1_en_q;
    out_en_d = out_en_q;
    err_d    = err_q;
    if (in_xfer) s1_en_d = in_en;
    if (s2_adv)  out_en_d = s1_en_q;
    if (out_valid_q && (multi_hot || ((|out_q) && !out_en_q))) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      s1_en_q  <= 1'b0;
      out_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_en_q  <= s1_en_d;
      out_en_q <= out_en_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hi_d     = s1_hi_q;
    s1_lo_d     = s1_lo_q;
    s1_sel_d    = s1_sel_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_hi_d    = hi_dec;
      s1_lo_d    = lo_dec;
      s1_sel_d   = in_sel;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // Output register only loads on advance, so it holds steady while stalled.
    if (s2_adv) begin
      out_valid_d = 1'b1;
      out_d       = comb_out;
      out_sel_d   = s1_sel_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= '0;
      s1_lo_q     <= '0;
      s1_sel_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sel_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_lo_q     <= s1_lo_d;
      s1_sel_q    <= s1_sel_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/regfile_decoder_pipe.md
Name: regfile_decoder_pipe

Overview:
Parametrised, pipelined successor to the team's 5-to-32 predecoding decoder, used for register-file write/read select.
- Splits the N-bit select into an upper group (HI_BITS) and a lower group (N-HI_BITS).
- Predecodes each group into one-hot vectors, registers them, then ANDs them into a registered 2^N one-hot output.
- Valid/ready handshaking on both sides, so it sits between the writeback control path and the regfile without dropping requests under back-pressure.

Parameters:
N, 5, select width; output width is 2^N; legal range 2..8
HI_BITS, 3, width of the upper predecode group; legal range 1..N-1; lower group LO_BITS = N-HI_BITS
MASK_ZERO, 1, when 1, index 0 never asserts (hardwired $r0); when 0, index 0 decodes normally

Ports:
clock  input  1  single clock, all state on rising edge
ctrl_reset_n  input  1  synchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
in_en  input  1  enable; 0 produces an all-zero decode, still handshaked
in_sel  input  N  index to decode
out_valid  output  1  out/out_sel hold a valid result
out_ready  input  1  consumer accepts result this cycle
out  output  2^N  registered one-hot (or all-zero) decode
out_sel  output  N  in_sel of the same request, carried alongside

Behaviour:
- Reset: sampled on rising clock edge while ctrl_reset_n=0.
  - Clears s1_valid, out_valid, out, out_sel and all stage-1 vectors to 0.
  - in_ready=0 while ctrl_reset_n=0 (combinational gate).
  - Reset mid-operation flushes both stages; in-flight requests are lost, no partial output.
- Handshake: a transfer occurs on a cycle with valid=1 and ready=1 on that interface.
  - Data must stay stable while valid=1 and ready=0. The block itself guarantees this for out/out_sel.
- Stage 1 (predecode):
  - On input transfer, s1_hi[k] = in_en & (in_sel[N-1:LO_BITS]==k) for k in 0..2^HI_BITS-1.
  - s1_lo[j] = in_en & (in_sel[LO_BITS-1:0]==j) for j in 0..2^LO_BITS-1.
  - s1_sel = in_sel; s1_valid = 1.
- Stage 2 (combine):
  - On advance, out[i] = s1_hi[i / 2^LO_BITS] & s1_lo[i % 2^LO_BITS].
  - If MASK_ZERO=1, out[0]=0.
  - out_sel = s1_sel; out_valid = 1.
- Advance rules:
  - s2_adv = s1_valid & (!out_valid | out_ready)
  - in_ready = ctrl_reset_n & (!s1_valid | s2_adv)
  - out_valid clears on an output transfer without simultaneous s2_adv.
  - s1_valid clears on s2_adv without simultaneous input transfer.
- Latency: 2 cycles, input transfer to out_valid.
- Throughput: 1 request/cycle when out_ready is held high.
- Back-pressure: with out_ready=0, at most 2 requests are buffered (stage 1 plus output); in_ready then drops the same cycle.
  - Simultaneous output transfer and new input in the full state: pipeline shifts, no bubble, no loss.
- Output invariant: out is exactly one-hot, or all-zero when en=0 or (MASK_ZERO=1 and sel=0).
- Out-of-range parameters: elaboration error (generate-time check), no silent clamping.

Optional Feature:
DEC_ONEHOT_CHECK_EN
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err is a registered sticky flag, set on any cycle where out_valid=1 and out has more than one bit set, or out has any bit set while the request's in_en was 0.
  - in_en is carried as an extra stage bit for this check.
  - err is cleared only by reset.
- Not defined: no err port, no extra logic; behaviour otherwise identical.

Test Plan:
1. N=5, HI_BITS=3, MASK_ZERO=1; in_sel=5, in_en=1, out_ready=1 -> exactly 2 cycles later out=32'h0000_0020, out_sel=5, out_valid for 1 cycle.
2. Stream in_sel=0..31 back-to-back, out_ready=1 -> 32 consecutive valid outputs, out=1<<i for i>=1, out=0 for i=0, in_ready never drops.
3. Send sel=3,7,9 with out_ready=0 -> in_ready falls after 2 accepts; out holds 32'h8 stable. Release out_ready -> 32'h8, 32'h80, 32'h200 in order, no duplicates.
4. in_en=0, in_sel=17 -> out_valid with out=0, out_sel=17. Rebuild with MASK_ZERO=0, in_sel=0, en=1 -> out=32'h1.
5. N=6, HI_BITS=2; in_sel=63 -> out bit 63 only. in_sel=36 -> bit 36 only.
6. Two requests in flight, assert ctrl_reset_n=0 for 1 cycle -> out_valid=0, out=0, in_ready=0 during reset. Next request decodes correctly with 2-cycle latency. With DEC_ONEHOT_CHECK_EN, err stays 0 throughout.
